instr_encode_loader: RTL and testbench

Sequential RV32I instruction encoder and instruction-memory loader. Accepts symbolic instruction requests (operation, register fields, immediate) over a valid/ready handshake, encodes them into 32-bit words for the opcode set the pipeline decodes (R-type, ADDI, LW, SW, BEQ), and writes them to consecutive instruction-memory locations. It sits beside the instruction memory and fills it from the testbench or a boot controller before the 5-stage pipeline is released from reset.

---
 rtl/instr_encode_loader_if.sv | 21 ++
 rtl/instr_encode_loader.sv | 176 +++++++++++++++++
 tb/tb_instr_encode_loader.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encode_loader_if.sv
// Request bus between an instruction source (testbench or boot
// controller) and the encoder/loader.
interface instr_encode_loader_if;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  op_sel;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [12:0] imm;

   modport master (
      output req_valid, op_sel, rd, rs1, rs2, imm,
      input  req_ready
   );

   modport slave (
      input  req_valid, op_sel, rd, rs1, rs2, imm,
      output req_ready
   );
endinterface

// File: rtl/instr_encode_loader.sv
// RV32I encoder and instruction-memory loader: turns symbolic requests
// (R-type, ADDI, LW, SW, BEQ) into 32-bit words and writes them to
// consecutive word addresses, one word every two cycles at best.
module instr_encode_loader #(
   parameter int          IMEM_DEPTH = 256,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_start,
   input  logic                        i_finish,
   instr_encode_loader_if.slave        req_if,
   output logic                        o_imem_we,
   output logic [31:0]                 o_imem_addr,
   output logic [31:0]                 o_imem_wdata,
   output logic [$clog2(IMEM_DEPTH):0] o_word_count,
   output logic                        o_busy,
   output logic                        o_done,
   output logic                        o_err,
   output logic [1:0]                  o_err_code
);
   localparam int            CW      = $clog2(IMEM_DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(IMEM_DEPTH);

   localparam logic [6:0] OPC_R    = 7'b0110011;
   localparam logic [6:0] OPC_ADDI = 7'b0010011;
   localparam logic [6:0] OPC_LW   = 7'b0000011;
   localparam logic [6:0] OPC_SW   = 7'b0100011;
   localparam logic [6:0] OPC_BEQ  = 7'b1100011;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE, S_ERR} state_t;

   state_t          r_state;
   logic            r_imem_we;
   logic [31:0]     r_imem_addr;
   logic [31:0]     r_imem_wdata;
   logic [CW-1:0]   r_word_count;
   logic            r_busy;
   logic            r_done;
   logic            r_err;
   logic [1:0]      r_err_code;

   state_t          w_state_next;
   logic            w_imem_we_next;
   logic [31:0]     w_imem_addr_next;
   logic [31:0]     w_imem_wdata_next;
   logic [CW-1:0]   w_word_count_next;
   logic [1:0]      w_err_code_next;

   logic            w_req_ready;
   logic            w_accept;
   logic [31:0]     w_enc;
   logic            w_bad;
   logic [1:0]      w_bad_code;
   logic            w_imm_ovf;

   // Ready is the only combinational output: open for business only in
   // LOAD and only while there is room left (no wrap-around).
   assign w_req_ready      = (r_state == S_LOAD) && (r_word_count < DEPTH_C);
   assign w_accept         = w_req_ready && req_if.req_valid;
   assign req_if.req_ready = w_req_ready;

   // 12-bit immediates are carried in a 13-bit field; they fit only when
   // the top two bits agree.
   assign w_imm_ovf = req_if.imm[12] ^ req_if.imm[11];

   // Encode the request and flag immediates the instruction cannot hold.
   always_comb begin
      w_enc      = '0;
      w_bad      = 1'b0;
      w_bad_code = 2'b00;
      case (req_if.op_sel)
         3'd0: w_enc = {7'b0000000, req_if.rs2, req_if.rs1, 3'b000, req_if.rd, OPC_R};
         3'd1: w_enc = {7'b0100000, req_if.rs2, req_if.rs1, 3'b000, req_if.rd, OPC_R};
         3'd2: w_enc = {7'b0000000, req_if.rs2, req_if.rs1, 3'b111, req_if.rd, OPC_R};
         3'd3: w_enc = {7'b0000000, req_if.rs2, req_if.rs1, 3'b110, req_if.rd, OPC_R};
         3'd4: begin
            w_enc      = {req_if.imm[11:0], req_if.rs1, 3'b000, req_if.rd, OPC_ADDI};
            w_bad      = w_imm_ovf;
            w_bad_code = 2'b01;
         end
         3'd5: begin
            w_enc      = {req_if.imm[11:0], req_if.rs1, 3'b010, req_if.rd, OPC_LW};
            w_bad      = w_imm_ovf;
            w_bad_code = 2'b01;
         end
         3'd6: begin
            w_enc      = {req_if.imm[11:5], req_if.rs2, req_if.rs1, 3'b010,
                          req_if.imm[4:0], OPC_SW};
            w_bad      = w_imm_ovf;
            w_bad_code = 2'b01;
         end
         default: begin
            w_enc      = {req_if.imm[12], req_if.imm[10:5], req_if.rs2, req_if.rs1,
                          3'b000, req_if.imm[4:1], req_if.imm[11], OPC_BEQ};
            w_bad      = req_if.imm[0];
            w_bad_code = 2'b10;
         end
      endcase
   end

   // Next-state and next-output decode; registers hold unless a state says otherwise.
   always_comb begin
      w_state_next      = r_state;
      w_imem_we_next    = 1'b0;
      w_imem_addr_next  = r_imem_addr;
      w_imem_wdata_next = r_imem_wdata;
      w_word_count_next = r_word_count;
      w_err_code_next   = r_err_code;
      case (r_state)
         S_IDLE, S_DONE, S_ERR: begin
            if (i_start) begin
               w_state_next      = S_LOAD;
               w_word_count_next = '0;
               w_err_code_next   = 2'b00;
            end
         end
         S_LOAD: begin
            // A request beats a simultaneous finish; start is ignored here.
            if (w_accept) begin
               if (w_bad) begin
                  w_state_next    = S_ERR;
                  w_err_code_next = w_bad_code;
               end else begin
                  w_state_next      = S_WRITE;
                  w_imem_we_next    = 1'b1;
                  w_imem_addr_next  = BASE_ADDR + 32'({r_word_count, 2'b00});
                  w_imem_wdata_next = w_enc;
               end
            end else if (i_finish) begin
               w_state_next = S_DONE;
            end
         end
         S_WRITE: begin
            w_state_next      = S_LOAD;
            w_word_count_next = r_word_count + CW'(1);
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // State and registered outputs; status flags follow the next state so
   // done/err are mutually exclusive by construction.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_imem_we    <= 1'b0;
         r_imem_addr  <= '0;
         r_imem_wdata <= '0;
         r_word_count <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
         r_err_code   <= 2'b00;
      end else begin
         r_state      <= w_state_next;
         r_imem_we    <= w_imem_we_next;
         r_imem_addr  <= w_imem_addr_next;
         r_imem_wdata <= w_imem_wdata_next;
         r_word_count <= w_word_count_next;
         r_busy       <= (w_state_next == S_LOAD) || (w_state_next == S_WRITE);
         r_done       <= (w_state_next == S_DONE);
         r_err        <= (w_state_next == S_ERR);
         r_err_code   <= w_err_code_next;
      end
   end

   assign o_imem_we    = r_imem_we;
   assign o_imem_addr  = r_imem_addr;
   assign o_imem_wdata = r_imem_wdata;
   assign o_word_count = r_word_count;
   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_err        = r_err;
   assign o_err_code   = r_err_code;
endmodule

// File: tb/tb_instr_encode_loader.sv
// Scoreboard bench for instr_encode_loader: expected writes are queued at
// accept time and popped when the write strobe appears.
module tb_instr_encode_loader;
   localparam int          DEPTH = 4;
   localparam logic [31:0] BASE  = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        srst;
   logic        start;
   logic        finish;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic [2:0]  word_count;
   logic        busy;
   logic        done;
   logic        err;
   logic [1:0]  err_code;

   int checks   = 0;
   int failures = 0;
   int exp_wc   = 0;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;
   wr_t exp_q[$];

   instr_encode_loader_if req_if ();

   instr_encode_loader #(.IMEM_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
      .i_clk        (clk),
      .i_rst        (srst),
      .i_start      (start),
      .i_finish     (finish),
      .req_if       (req_if),
      .o_imem_we    (imem_we),
      .o_imem_addr  (imem_addr),
      .o_imem_wdata (imem_wdata),
      .o_word_count (word_count),
      .o_busy       (busy),
      .o_done       (done),
      .o_err        (err),
      .o_err_code   (err_code)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end else begin
         $display("ok   %s: 0x%08h", tag, obs);
      end
   endtask

   // Reference R-type encoder built from shifted fields.
   function automatic logic [31:0] ref_r(input int op, input int rd, input int rs1, input int rs2);
      int f7;
      int f3;
      f7 = (op == 1) ? 32 : 0;
      f3 = (op == 2) ? 7 : (op == 3) ? 6 : 0;
      return 32'((f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h33);
   endfunction

   // Write monitor: every strobe must match the oldest queued expectation.
   always @(negedge clk) begin
      if (imem_we) begin
         if (exp_q.size() == 0) begin
            check_eq("spurious_we", {31'b0, imem_we}, 32'd0);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check_eq("wr_addr", imem_addr, e.addr);
            check_eq("wr_data", imem_wdata, e.data);
         end
      end
   end

   task automatic send_req(input string tag, input logic [2:0] op, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm,
                           input bit exp_accept, input bit exp_write, input logic [31:0] exp_data);
      bit accepted;
      wr_t e;
      req_if.req_valid = 1'b1;
      req_if.op_sel    = op;
      req_if.rd        = rd;
      req_if.rs1       = rs1;
      req_if.rs2       = rs2;
      req_if.imm       = imm;
      accepted = 1'b0;
      for (int c = 0; c < 8 && !accepted; c++) begin
         @(negedge clk);
         if (req_if.req_ready) begin
            @(posedge clk);
            accepted = 1'b1;
            if (exp_write) begin
               e.addr = BASE + 32'(exp_wc * 4);
               e.data = exp_data;
               exp_q.push_back(e);
               exp_wc++;
            end
         end
      end
      #1 req_if.req_valid = 1'b0;
      check_eq({"accept_", tag}, {31'b0, accepted}, {31'b0, exp_accept});
   endtask

   task automatic start_session();
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      exp_wc = 0;
   endtask

   task automatic finish_session(input string tag);
      finish = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk);
         #1;
         if (done) break;
      end
      finish = 1'b0;
      check_eq({"done_", tag}, {31'b0, done}, 32'd1);
      check_eq({"busy_", tag}, {31'b0, busy}, 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_we"},    {31'b0, imem_we}, 32'd0);
      check_eq({tag, "_addr"},  imem_addr, 32'd0);
      check_eq({tag, "_wdata"}, imem_wdata, 32'd0);
      check_eq({tag, "_wc"},    {29'b0, word_count}, 32'd0);
      check_eq({tag, "_busy"},  {31'b0, busy}, 32'd0);
      check_eq({tag, "_done"},  {31'b0, done}, 32'd0);
      check_eq({tag, "_err"},   {31'b0, err}, 32'd0);
      check_eq({tag, "_code"},  {30'b0, err_code}, 32'd0);
      check_eq({tag, "_ready"}, {31'b0, req_if.req_ready}, 32'd0);
   endtask

   initial begin
      srst = 1'b1;
      start = 1'b0;
      finish = 1'b0;
      req_if.req_valid = 1'b0;
      req_if.op_sel = 3'd0;
      req_if.rd = '0;
      req_if.rs1 = '0;
      req_if.rs2 = '0;
      req_if.imm = '0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      srst = 1'b0;

      // Single ADDI
      start_session();
      check_eq("busy_after_start", {31'b0, busy}, 32'd1);
      send_req("addi", 3'd4, 5'd1, 5'd0, 5'd0, 13'd5, 1'b1, 1'b1, 32'h0050_0093);
      @(posedge clk);
      #1 check_eq("wc_after_addi", {29'b0, word_count}, 32'd1);
      finish_session("s1");

      // SUB then SW back-to-back
      start_session();
      check_eq("wc_cleared", {29'b0, word_count}, 32'd0);
      send_req("sub", 3'd1, 5'd3, 5'd1, 5'd2, 13'd0, 1'b1, 1'b1, 32'h4020_81B3);
      send_req("sw", 3'd6, 5'd0, 5'd1, 5'd2, 13'd8, 1'b1, 1'b1, 32'h0020_A423);
      finish_session("s2");
      check_eq("wc_s2", {29'b0, word_count}, 32'd2);

      // Negative immediates
      start_session();
      send_req("lw", 3'd5, 5'd5, 5'd6, 5'd0, 13'h1FFC, 1'b1, 1'b1, 32'hFFC3_2283);
      send_req("beq", 3'd7, 5'd0, 5'd1, 5'd2, 13'h1FF8, 1'b1, 1'b1, 32'hFE20_8CE3);
      finish_session("s3");

      // Immediate out of range
      start_session();
      send_req("addi_ovf", 3'd4, 5'd1, 5'd0, 5'd0, 13'h0800, 1'b1, 1'b0, 32'd0);
      check_eq("err_ovf", {31'b0, err}, 32'd1);
      check_eq("code_ovf", {30'b0, err_code}, 32'd1);
      check_eq("done_in_err", {31'b0, done}, 32'd0);
      check_eq("busy_in_err", {31'b0, busy}, 32'd0);
      check_eq("ready_in_err", {31'b0, req_if.req_ready}, 32'd0);

      // Misaligned branch
      start_session();
      check_eq("err_cleared", {31'b0, err}, 32'd0);
      send_req("beq_odd", 3'd7, 5'd0, 5'd1, 5'd2, 13'd3, 1'b1, 1'b0, 32'd0);
      check_eq("code_misalign", {30'b0, err_code}, 32'd2);
      check_eq("err_misalign", {31'b0, err}, 32'd1);
      start_session();
      check_eq("err_after_start", {31'b0, err}, 32'd0);
      check_eq("code_after_start", {30'b0, err_code}, 32'd0);
      check_eq("wc_after_start", {29'b0, word_count}, 32'd0);

      // Fill to capacity, fifth request must stall
      for (int i = 0; i < 4; i++) begin
         int op, rd, r1, r2;
         op = $urandom_range(0, 3);
         rd = $urandom_range(0, 31);
         r1 = $urandom_range(0, 31);
         r2 = $urandom_range(0, 31);
         send_req("fill", 3'(op), 5'(rd), 5'(r1), 5'(r2), 13'd0, 1'b1, 1'b1, ref_r(op, rd, r1, r2));
      end
      send_req("full", 3'd0, 5'd1, 5'd1, 5'd1, 13'd0, 1'b0, 1'b0, 32'd0);
      check_eq("wc_full", {29'b0, word_count}, 32'd4);
      check_eq("ready_full", {31'b0, req_if.req_ready}, 32'd0);
      check_eq("busy_full", {31'b0, busy}, 32'd1);
      finish_session("full");
      check_eq("wc_full_done", {29'b0, word_count}, 32'd4);

      // Reset during the write cycle
      start_session();
      send_req("addi_rst", 3'd4, 5'd2, 5'd2, 5'd0, 13'd1, 1'b1, 1'b1, 32'h0011_0113);
      srst = 1'b1;
      @(posedge clk);
      #1;
      check_reset_outputs("midrst");
      srst = 1'b0;

      // Request and finish together: request wins
      start_session();
      finish = 1'b1;
      send_req("addi_fin", 3'd4, 5'd1, 5'd0, 5'd0, 13'd5, 1'b1, 1'b1, 32'h0050_0093);
      finish = 1'b0;
      @(posedge clk);
      #1;
      check_eq("busy_req_fin", {31'b0, busy}, 32'd1);
      check_eq("done_req_fin", {31'b0, done}, 32'd0);
      check_eq("wc_req_fin", {29'b0, word_count}, 32'd1);

      // start and finish together in LOAD: finish honoured, count kept
      start = 1'b1;
      finish = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      finish = 1'b0;
      check_eq("done_start_fin", {31'b0, done}, 32'd1);
      check_eq("wc_start_fin", {29'b0, word_count}, 32'd1);

      repeat (2) @(posedge clk);
      #1 check_eq("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
